// File: rtl/vec_pipe_chain.sv
// In-order pipeline register chain carrying a control word and vector payload,
// with per-stage valid/flush, global stall and youngest-producer forwarding.
module vec_pipe_chain #(
    parameter  int STAGES = 3,
    parameter  int LANES  = 4,
    parameter  int LANE_W = 8,
    parameter  int CTRL_W = 25,
    parameter  int SEL_W  = 4,
    localparam int VEC_W  = LANES * LANE_W,
    localparam int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [VEC_W-1:0]  in_vec,
    input  logic              in_wr_en,
    input  logic [SEL_W-1:0]  in_wr_reg,
    input  logic [LANES-1:0]  in_lane_mask,
    input  logic              stall,
    input  logic [STAGES-1:0] flush_mask,
    output logic              in_ready,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [VEC_W-1:0]  out_vec,
    output logic              out_wr_en,
    output logic [SEL_W-1:0]  out_wr_reg,
    output logic [LANES-1:0]  out_lane_mask,
    input  logic [SEL_W-1:0]  q_reg_a,
    input  logic [SEL_W-1:0]  q_reg_b,
    output logic              hit_a,
    output logic              hit_b,
    output logic              partial_a,
    output logic              partial_b,
    output logic [VEC_W-1:0]  fwd_a,
    output logic [VEC_W-1:0]  fwd_b,
    output logic [OCC_W-1:0]  occupancy
);

    logic [STAGES-1:0] valid_q;
    logic [CTRL_W-1:0] ctrl_q  [STAGES];
    logic [VEC_W-1:0]  vec_q   [STAGES];
    logic              wr_en_q [STAGES];
    logic [SEL_W-1:0]  wr_reg_q[STAGES];
    logic [LANES-1:0]  mask_q  [STAGES];

    assign in_ready = !stall;

    // Flush is applied to the valid bits whether the chain advances or holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                ctrl_q[i]   <= '0;
                vec_q[i]    <= '0;
                wr_en_q[i]  <= 1'b0;
                wr_reg_q[i] <= '0;
                mask_q[i]   <= '0;
            end
        end else if (!stall) begin
            valid_q[0]  <= in_valid;
            ctrl_q[0]   <= in_ctrl;
            vec_q[0]    <= in_vec;
            wr_en_q[0]  <= in_wr_en;
            wr_reg_q[0] <= in_wr_reg;
            mask_q[0]   <= in_lane_mask;
            for (int i = 1; i < STAGES; i++) begin
                valid_q[i]  <= valid_q[i-1] & !flush_mask[i-1];
                ctrl_q[i]   <= ctrl_q[i-1];
                vec_q[i]    <= vec_q[i-1];
                wr_en_q[i]  <= wr_en_q[i-1];
                wr_reg_q[i] <= wr_reg_q[i-1];
                mask_q[i]   <= mask_q[i-1];
            end
        end else begin
            valid_q <= valid_q & ~flush_mask;
        end
    end

    assign out_valid     = valid_q[STAGES-1];
    assign out_ctrl      = ctrl_q[STAGES-1];
    assign out_vec       = vec_q[STAGES-1];
    assign out_wr_en     = valid_q[STAGES-1] & wr_en_q[STAGES-1];
    assign out_wr_reg    = wr_reg_q[STAGES-1];
    assign out_lane_mask = mask_q[STAGES-1];

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        hit_a     = 1'b0;
        partial_a = 1'b0;
        fwd_a     = '0;
        hit_b     = 1'b0;
        partial_b = 1'b0;
        fwd_b     = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (valid_q[i] && wr_en_q[i] && !flush_mask[i] && wr_reg_q[i] == q_reg_a) begin
                hit_a     = 1'b1;
                partial_a = !(&mask_q[i]);
                fwd_a     = vec_q[i];
            end
            if (valid_q[i] && wr_en_q[i] && !flush_mask[i] && wr_reg_q[i] == q_reg_b) begin
                hit_b     = 1'b1;
                partial_b = !(&mask_q[i]);
                fwd_b     = vec_q[i];
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OCC_W'(valid_q[i]);
        end
    end

endmodule

// File: tb/tb_vec_pipe_chain.sv
// Directed self-checking bench for vec_pipe_chain with the default 3-stage,
// 4x8-bit configuration; expected values are hand-computed per step.
module tb_vec_pipe_chain;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [24:0] in_ctrl;
    logic [31:0] in_vec;
    logic        in_wr_en;
    logic [3:0]  in_wr_reg;
    logic [3:0]  in_lane_mask;
    logic        stall;
    logic [2:0]  flush_mask;
    logic        in_ready;
    logic        out_valid;
    logic [24:0] out_ctrl;
    logic [31:0] out_vec;
    logic        out_wr_en;
    logic [3:0]  out_wr_reg;
    logic [3:0]  out_lane_mask;
    logic [3:0]  q_reg_a;
    logic [3:0]  q_reg_b;
    logic        hit_a;
    logic        hit_b;
    logic        partial_a;
    logic        partial_b;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [1:0]  occupancy;

    int checks;
    int failures;

    vec_pipe_chain dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .in_vec(in_vec),
        .in_wr_en(in_wr_en), .in_wr_reg(in_wr_reg), .in_lane_mask(in_lane_mask),
        .stall(stall), .flush_mask(flush_mask), .in_ready(in_ready),
        .out_valid(out_valid), .out_ctrl(out_ctrl), .out_vec(out_vec),
        .out_wr_en(out_wr_en), .out_wr_reg(out_wr_reg), .out_lane_mask(out_lane_mask),
        .q_reg_a(q_reg_a), .q_reg_b(q_reg_b),
        .hit_a(hit_a), .hit_b(hit_b), .partial_a(partial_a), .partial_b(partial_b),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .occupancy(occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic v, input logic [24:0] c, input logic [31:0] vec,
                                 input logic we, input logic [3:0] reg_sel, input logic [3:0] mask);
        in_valid     = v;
        in_ctrl      = c;
        in_vec       = vec;
        in_wr_en     = we;
        in_wr_reg    = reg_sel;
        in_lane_mask = mask;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst        = 1'b0;
        stall      = 1'b0;
        flush_mask = 3'b000;
        q_reg_a    = 4'd0;
        q_reg_b    = 4'd0;
        applyStimulus(1'b0, 25'd0, 32'h0, 1'b0, 4'd0, 4'h0);

        tick();
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_occupancy", occupancy, 2'd0);
        tick();
        checkOutput("rst_hit_a", hit_a, 1'b0);
        checkOutput("rst_out_ctrl", out_ctrl, 25'd0);
        rst = 1'b1;

        // Fill with ctrl 1,2,3
        applyStimulus(1'b1, 25'd1, 32'h0000_0001, 1'b1, 4'd1, 4'hF);
        tick();
        checkOutput("fill_occ1", occupancy, 2'd1);
        checkOutput("fill_out_valid0", out_valid, 1'b0);
        applyStimulus(1'b1, 25'd2, 32'h0000_0002, 1'b1, 4'd1, 4'hF);
        tick();
        checkOutput("fill_occ2", occupancy, 2'd2);
        applyStimulus(1'b1, 25'd3, 32'h0000_0003, 1'b1, 4'd1, 4'hF);
        tick();
        checkOutput("fill_occ3", occupancy, 2'd3);
        checkOutput("fill_out_ctrl1", out_ctrl, 25'd1);
        checkOutput("fill_out_valid1", out_valid, 1'b1);

        // Stall for 4 cycles with a pending ctrl=4 on the input
        stall = 1'b1;
        applyStimulus(1'b1, 25'd4, 32'h0000_0004, 1'b1, 4'd1, 4'hF);
        #1;
        checkOutput("stall_in_ready", in_ready, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("stall_out_ctrl", out_ctrl, 25'd1);
            checkOutput("stall_out_vec", out_vec, 32'h0000_0001);
            checkOutput("stall_occ", occupancy, 2'd3);
        end
        stall = 1'b0;
        #1;
        checkOutput("release_in_ready", in_ready, 1'b1);
        tick();
        checkOutput("resume_out_ctrl2", out_ctrl, 25'd2);
        applyStimulus(1'b1, 25'd5, 32'h0000_0005, 1'b1, 4'd1, 4'hF);
        tick();
        checkOutput("resume_out_ctrl3", out_ctrl, 25'd3);
        applyStimulus(1'b1, 25'd6, 32'h0000_0006, 1'b1, 4'd1, 4'hF);
        tick();
        checkOutput("resume_out_ctrl4", out_ctrl, 25'd4);

        // ctrl=5 sits in stage1; flush it while advancing
        flush_mask = 3'b010;
        applyStimulus(1'b1, 25'd7, 32'h0000_0007, 1'b1, 4'd1, 4'hF);
        tick();
        flush_mask = 3'b000;
        checkOutput("flush_adv_out_valid", out_valid, 1'b0);
        checkOutput("flush_adv_occ", occupancy, 2'd2);
        applyStimulus(1'b1, 25'd8, 32'h0000_0008, 1'b1, 4'd1, 4'hF);
        tick();
        checkOutput("after_flush_out_ctrl6", out_ctrl, 25'd6);
        checkOutput("after_flush_out_valid", out_valid, 1'b1);
        checkOutput("after_flush_occ", occupancy, 2'd3);

        // Flush stage1 (ctrl=7) under stall
        stall      = 1'b1;
        flush_mask = 3'b010;
        tick();
        flush_mask = 3'b000;
        checkOutput("flush_stall_occ", occupancy, 2'd2);
        checkOutput("flush_stall_out_ctrl", out_ctrl, 25'd6);
        stall = 1'b0;
        applyStimulus(1'b0, 25'd0, 32'h0, 1'b0, 4'd0, 4'h0);
        tick();
        checkOutput("flush_stall_out_valid", out_valid, 1'b0);
        checkOutput("flush_stall_occ1", occupancy, 2'd1);
        tick();
        checkOutput("drain_out_ctrl8", out_ctrl, 25'd8);
        checkOutput("drain_out_valid", out_valid, 1'b1);
        tick();
        checkOutput("empty_occ", occupancy, 2'd0);

        // Forwarding priority: r3 (AAAAAAAA) oldest, r5 middle, r3 (04030201) youngest
        applyStimulus(1'b1, 25'd10, 32'hAAAA_AAAA, 1'b1, 4'd3, 4'hF);
        tick();
        applyStimulus(1'b1, 25'd11, 32'h1111_1111, 1'b1, 4'd5, 4'hF);
        tick();
        applyStimulus(1'b1, 25'd12, 32'h0403_0201, 1'b1, 4'd3, 4'hF);
        tick();
        stall = 1'b1;
        applyStimulus(1'b0, 25'd0, 32'h0, 1'b0, 4'd0, 4'h0);
        q_reg_a = 4'd3;
        #1;
        checkOutput("fwd_hit_a", hit_a, 1'b1);
        checkOutput("fwd_a_youngest", fwd_a, 32'h0403_0201);
        checkOutput("fwd_partial_a", partial_a, 1'b0);
        flush_mask = 3'b001;
        #1;
        checkOutput("fwd_a_flush0", fwd_a, 32'hAAAA_AAAA);
        checkOutput("fwd_hit_a_flush0", hit_a, 1'b1);
        flush_mask = 3'b000;
        q_reg_a = 4'd5;
        #1;
        checkOutput("fwd_a_r5", fwd_a, 32'h1111_1111);
        q_reg_a = 4'd7;
        #1;
        checkOutput("miss_hit_a", hit_a, 1'b0);
        checkOutput("miss_fwd_a", fwd_a, 32'h0);

        // Partial scalar producer of r2
        stall = 1'b0;
        applyStimulus(1'b1, 25'd13, 32'h0000_00BB, 1'b1, 4'd2, 4'b0001);
        tick();
        stall = 1'b1;
        applyStimulus(1'b0, 25'd0, 32'h0, 1'b0, 4'd0, 4'h0);
        q_reg_b = 4'd2;
        #1;
        checkOutput("partial_hit_b", hit_b, 1'b1);
        checkOutput("partial_b", partial_b, 1'b1);
        checkOutput("partial_fwd_b", fwd_b, 32'h0000_00BB);
        checkOutput("out_wr_en_r5", out_wr_en, 1'b1);
        checkOutput("out_wr_reg_r5", out_wr_reg, 4'd5);

        // Fill with non-writing r2 instructions
        stall = 1'b0;
        applyStimulus(1'b1, 25'd14, 32'h0000_00CC, 1'b0, 4'd2, 4'hF);
        tick();
        tick();
        tick();
        checkOutput("nowr_hit_b", hit_b, 1'b0);
        checkOutput("nowr_out_valid", out_valid, 1'b1);
        checkOutput("nowr_out_wr_en", out_wr_en, 1'b0);
        checkOutput("nowr_occ", occupancy, 2'd3);

        // Async reset between edges with a full chain
        applyStimulus(1'b1, 25'd15, 32'h0000_00DD, 1'b1, 4'd3, 4'hF);
        tick();
        applyStimulus(1'b0, 25'd0, 32'h0, 1'b0, 4'd0, 4'h0);
        stall   = 1'b1;
        q_reg_a = 4'd3;
        #1;
        checkOutput("pre_arst_hit_a", hit_a, 1'b1);
        checkOutput("pre_arst_occ", occupancy, 2'd3);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("arst_out_valid", out_valid, 1'b0);
        checkOutput("arst_hit_a", hit_a, 1'b0);
        checkOutput("arst_occ", occupancy, 2'd0);
        checkOutput("arst_out_ctrl", out_ctrl, 25'd0);
        tick();
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
